// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared request type, FIFO pointer sizing helper and reset
// constants for the memory request front-end. The request struct is sized by
// MEM_WIDTH / MEM_ADDR_WIDTH, which are also the defaults of the top-level
// WIDTH / ADDR_WIDTH parameters; the two must stay equal.
package mem_req_pkg;

  localparam int MEM_WIDTH      = 8;
  localparam int MEM_ADDR_WIDTH = 4;

  typedef struct packed {
    logic                      we;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_WIDTH-1:0]      wdata;
  } mem_req_t;

  localparam mem_req_t REQ_RST = '0;

  // One extra pointer bit distinguishes full from empty.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_req_sequencer_fifo.sv
// mem_rsp_fifo: synchronous response FIFO. Head is always visible on o_dout;
// storage is cleared on reset so the head reads zero until the first push.
module mem_rsp_fifo
  import mem_req_pkg::*;
#(
  parameter int WIDTH     = MEM_WIDTH,
  parameter int RSP_DEPTH = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_push,
  input  logic [WIDTH-1:0]                    i_din,
  input  logic                                i_pop,
  output logic [WIDTH-1:0]                    o_dout,
  output logic                                o_empty,
  output logic [fifo_ptr_w(RSP_DEPTH)-1:0]    o_count
);

  localparam int PW = fifo_ptr_w(RSP_DEPTH);

  logic [WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;

  // Write and read pointers; a push and pop on the same edge leave the count unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Storage array, written at the low bits of the write pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RSP_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push) begin
      r_mem[r_wr_ptr[PW-2:0]] <= i_din;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr[PW-2:0]];
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (o_count == '0);

endmodule

// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: request front-end for one memory port. Registers accepted
// requests onto the memory port, tracks reads against the fixed read latency,
// and returns read data in order through a backpressured response FIFO.
// Credit accounting keeps in-flight reads plus FIFO occupancy within RSP_DEPTH.
// Build option MEM_REQ_HAZARD_CHK_EN adds a write scoreboard that stalls reads
// to addresses still being written, so read-after-write returns the new data.
module mem_req_sequencer
  import mem_req_pkg::*;
#(
  parameter int WIDTH      = MEM_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int RD_LAT     = 6,
  parameter int WR_LAT     = 4,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [WIDTH-1:0]      i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [WIDTH-1:0]      o_rsp_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WIDTH-1:0]      o_mem_din,
  input  logic [WIDTH-1:0]      i_mem_dout,
  output logic                  o_idle
);

  localparam int PW = fifo_ptr_w(RSP_DEPTH);
  localparam int CW = $clog2(RD_LAT + RSP_DEPTH + 2);

  logic              w_accept;
  logic              w_rd_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;
  logic [PW-1:0]     w_fifo_count;
  logic [CW-1:0]     w_inflight_cnt;
  logic [CW-1:0]     w_credit_used;
  logic              w_credit_ok;
  logic              w_hazard;
  logic              w_wr_pend;

  mem_req_t          r_issue;
  logic              r_mem_en;
  logic              r_ready_en;
  logic [RD_LAT-1:0] r_inflight;

  assign w_accept = i_req_valid & o_req_ready;

  // Issue register: a request is presented to the memory for exactly one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_en <= 1'b0;
      r_issue  <= REQ_RST;
    end else begin
      r_mem_en <= w_accept;
      if (w_accept) begin
        r_issue.we    <= i_req_we;
        r_issue.addr  <= i_req_addr;
        r_issue.wdata <= i_req_wdata;
      end else begin
        r_issue.we    <= 1'b0;
      end
    end
  end

  // Ready is held low through reset and rises on the first edge after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ready_en <= 1'b0;
    else          r_ready_en <= 1'b1;
  end

  // A read enters tracking at the memory's sampling edge; its bit leaving the
  // register marks the edge at which i_mem_dout carries its data.
  assign w_rd_issue = r_mem_en & ~r_issue.we;
  assign w_push     = r_inflight[RD_LAT-1];
  assign w_pop      = o_rsp_valid & i_rsp_ready;

  // Read-in-flight shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_inflight <= '0;
    else          r_inflight <= RD_LAT'({r_inflight, w_rd_issue});
  end

  mem_rsp_fifo #(
    .WIDTH     (WIDTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_din   (i_mem_dout),
    .i_pop   (w_pop),
    .o_dout  (o_rsp_rdata),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign o_rsp_valid = ~w_fifo_empty;

  // Credit: every read already committed (presented, tracked or buffered) holds
  // one FIFO slot. Writes stall too so request order is never broken.
  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight_cnt = w_inflight_cnt + CW'(r_inflight[i]);
  end

  assign w_credit_used = w_inflight_cnt + CW'(w_fifo_count) + CW'(w_rd_issue);
  assign w_credit_ok   = (w_credit_used < CW'(RSP_DEPTH));

`ifdef MEM_REQ_HAZARD_CHK_EN
  logic [WR_LAT-1:0]     r_wp_vld;
  logic [ADDR_WIDTH-1:0] r_wp_addr [WR_LAT];

  // Write scoreboard: one entry per cycle a write may still be landing in the array.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp_vld <= '0;
      for (int i = 0; i < WR_LAT; i++) r_wp_addr[i] <= '0;
    end else begin
      r_wp_vld     <= WR_LAT'({r_wp_vld, w_accept & i_req_we});
      r_wp_addr[0] <= i_req_addr;
      for (int i = 1; i < WR_LAT; i++) r_wp_addr[i] <= r_wp_addr[i-1];
    end
  end

  // Stall a read whose address matches any write still in the window.
  always_comb begin
    w_hazard = 1'b0;
    if (!i_req_we) begin
      if (r_mem_en && r_issue.we && (r_issue.addr == i_req_addr)) w_hazard = 1'b1;
      for (int i = 0; i < WR_LAT; i++) begin
        if (r_wp_vld[i] && (r_wp_addr[i] == i_req_addr)) w_hazard = 1'b1;
      end
    end
  end

  assign w_wr_pend = |r_wp_vld;
`else
  localparam int TW = $clog2(WR_LAT + 1);
  logic [TW-1:0] r_wr_tmr;

  // Write-pending down-counter: reloads on each write, idle reports busy until it expires.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                  r_wr_tmr <= '0;
    else if (w_accept && i_req_we) r_wr_tmr <= TW'(WR_LAT);
    else if (r_wr_tmr != '0)       r_wr_tmr <= r_wr_tmr - TW'(1);
  end

  assign w_hazard  = 1'b0;
  assign w_wr_pend = (r_wr_tmr != '0);
`endif

  assign o_req_ready = r_ready_en & w_credit_ok & ~w_hazard;

  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_issue.we;
  assign o_mem_addr  = r_issue.addr;
  assign o_mem_din   = r_issue.wdata;

  assign o_idle = ~r_mem_en & ~(|r_inflight) & w_fifo_empty & ~w_wr_pend;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb_mem_req_sequencer: directed bench for mem_req_sequencer with a behavioural
// memory (read latency RD_LAT-1, writes land WR_LAT edges after sampling) and a
// response scoreboard. Build with MEM_REQ_HAZARD_CHK_EN to cover the hazard stall.
module tb_mem_req_sequencer;

  localparam int WIDTH      = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int RD_LAT     = 6;
  localparam int WR_LAT     = 4;
  localparam int RSP_DEPTH  = 4;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n = 1'b0;
  logic                  i_req_valid = 1'b0;
  logic                  o_req_ready;
  logic                  i_req_we = 1'b0;
  logic [ADDR_WIDTH-1:0] i_req_addr = '0;
  logic [WIDTH-1:0]      i_req_wdata = '0;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready = 1'b1;
  logic [WIDTH-1:0]      o_rsp_rdata;
  logic                  o_mem_en;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [WIDTH-1:0]      o_mem_din;
  logic [WIDTH-1:0]      i_mem_dout;
  logic                  o_idle;

  always #5 i_clk = ~i_clk;

  mem_req_sequencer #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LAT     (RD_LAT),
    .WR_LAT     (WR_LAT),
    .RSP_DEPTH  (RSP_DEPTH)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_din   (o_mem_din),
    .i_mem_dout  (i_mem_dout),
    .o_idle      (o_idle)
  );

  // Behavioural memory port.
  logic [WIDTH-1:0]      mem     [16]     = '{default: '0};
  logic [WIDTH-1:0]      rd_pipe [RD_LAT] = '{default: '0};
  logic                  wp_vld  [WR_LAT] = '{default: 1'b0};
  logic [ADDR_WIDTH-1:0] wp_addr [WR_LAT] = '{default: '0};
  logic [WIDTH-1:0]      wp_data [WR_LAT] = '{default: '0};

  always @(posedge i_clk) begin
    if (wp_vld[WR_LAT-1]) mem[wp_addr[WR_LAT-1]] <= wp_data[WR_LAT-1];
    wp_vld[0]  <= o_mem_en & o_mem_we;
    wp_addr[0] <= o_mem_addr;
    wp_data[0] <= o_mem_din;
    for (int i = 1; i < WR_LAT; i++) begin
      wp_vld[i]  <= wp_vld[i-1];
      wp_addr[i] <= wp_addr[i-1];
      wp_data[i] <= wp_data[i-1];
    end
    rd_pipe[0] <= mem[o_mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign i_mem_dout = rd_pipe[RD_LAT-1];

  // Scoreboard and bookkeeping.
  logic [WIDTH-1:0] ref_mem [16] = '{default: '0};
  logic [WIDTH-1:0] exp_q [$];
  int   n_err = 0;
  int   n_chk = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   first_vld_cyc = -1;
  int   rsp_cnt = 0;
  bit   acc = 1'b0;
  bit   use_ovr = 1'b0;
  logic [WIDTH-1:0] ovr_val = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit we, input int a, input int d);
    i_req_valid = v;
    i_req_we    = we;
    i_req_addr  = ADDR_WIDTH'(a);
    i_req_wdata = WIDTH'(d);
  endtask

  // One clock cycle: sample mid-cycle, update the scoreboard, advance past the edge.
  task automatic tick();
    logic [WIDTH-1:0] e;
    @(negedge i_clk);
    acc = i_req_valid && o_req_ready;
    if (acc) begin
      if (i_req_we) ref_mem[i_req_addr] = i_req_wdata;
      else begin
        exp_q.push_back(use_ovr ? ovr_val : ref_mem[i_req_addr]);
        acc_cyc = cyc;
      end
    end
    if (o_rsp_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (o_rsp_valid && i_rsp_ready) begin
      rsp_cnt++;
      if (exp_q.size() == 0) chk("rsp_unexpected", 32'(o_rsp_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_data", 32'(o_rsp_rdata), 32'(e));
      end
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  // Present one request until accepted (bounded); returns stall cycles.
  task automatic send(input bit we, input int a, input int d, output int stalls);
    drive(1'b1, we, a, d);
    stalls = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (acc) break;
      stalls++;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    drive(1'b0, 1'b0, 0, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0 && o_idle) break;
      tick();
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int st;
    int sum_st;
    int a;
    int rc0;

    // Reset values
    #12;
    chk("rst_mem_en",    32'(o_mem_en),    32'd0);
    chk("rst_mem_we",    32'(o_mem_we),    32'd0);
    chk("rst_mem_addr",  32'(o_mem_addr),  32'd0);
    chk("rst_mem_din",   32'(o_mem_din),   32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(o_rsp_rdata), 32'd0);
    chk("rst_idle",      32'(o_idle),      32'd1);
    chk("rst_ready",     32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", 32'(o_req_ready), 32'd0);
    @(posedge i_clk);
    #1;
    chk("ready_post_edge", 32'(o_req_ready), 32'd1);

    // Write then read back with latency measurement
    send(1'b1, 3, 'hA5, st);
    for (int k = 0; k < 8; k++) tick();
    first_vld_cyc = -1;
    send(1'b0, 3, 0, st);
    for (int k = 0; k < 20 && first_vld_cyc < 0; k++) tick();
    chk("rd_latency", 32'(first_vld_cyc - acc_cyc), 32'(RD_LAT + 2));
    drain();

    // Pre-write 0..7, then back-to-back reads
    for (int i = 0; i < 8; i++) send(1'b1, i, 'h10 + i, st);
    rc0 = rsp_cnt;
    sum_st = 0;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, i, 0, st);
      if (i < RSP_DEPTH) sum_st += st;
    end
    chk("b2b_first_stalls", 32'(sum_st), 32'd0);
    drain();
    chk("b2b_rsp_count", 32'(rsp_cnt - rc0), 32'd8);

    // Backpressure: only RSP_DEPTH reads fit
    rc0 = rsp_cnt;
    i_rsp_ready = 1'b0;
    a = 0;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b0, a, 0);
      tick();
      if (acc) a++;
    end
    drive(1'b1, 1'b0, a, 0);
    chk("bp_accepts",   32'(a),           32'(RSP_DEPTH));
    chk("bp_ready_low", 32'(o_req_ready), 32'd0);
    chk("bp_hold_vld",  32'(o_rsp_valid), 32'd1);
    chk("bp_hold_data", 32'(o_rsp_rdata), 32'h10);
    i_rsp_ready = 1'b1;
    send(1'b0, a, 0, st);
    drain();
    chk("bp_rsp_count", 32'(rsp_cnt - rc0), 32'(RSP_DEPTH + 1));

    // Read-after-write to the same address
    send(1'b1, 5, 'h3C, st);
`ifdef MEM_REQ_HAZARD_CHK_EN
    send(1'b0, 5, 0, st);
    chk("haz_stall", 32'(st), 32'(WR_LAT));
`else
    use_ovr = 1'b1;
    ovr_val = 8'h15;
    send(1'b0, 5, 0, st);
    use_ovr = 1'b0;
    chk("haz_stall", 32'(st), 32'd0);
`endif
    drain();

    // Reset with reads in flight
    for (int i = 1; i <= 3; i++) send(1'b0, i, 0, st);
    tick();
    tick();
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_en",    32'(o_mem_en),    32'd0);
    chk("mid_rst_mem_we",    32'(o_mem_we),    32'd0);
    chk("mid_rst_mem_addr",  32'(o_mem_addr),  32'd0);
    chk("mid_rst_mem_din",   32'(o_mem_din),   32'd0);
    chk("mid_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("mid_rst_rsp_rdata", 32'(o_rsp_rdata), 32'd0);
    chk("mid_rst_idle",      32'(o_idle),      32'd1);
    chk("mid_rst_ready",     32'(o_req_ready), 32'd0);
    exp_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    first_vld_cyc = -1;
    for (int k = 0; k < 20; k++) tick();
    chk("no_stale_rsp", 32'(first_vld_cyc), 32'hFFFF_FFFF);
    chk("post_rst_idle", 32'(o_idle), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
